seq_array_mult: RTL and testbench



---
 rtl/seq_array_mult.sv | 165 ++++++++++++++++
 tb/tb_seq_array_mult.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_array_mult.sv
// -----------------------------------------------------------------------------
// seq_array_mult
//   Iterative unsigned/signed multiplier. Each iteration folds BITS_PER_CYCLE
//   multiplier bits into a 2*WIDTH-bit accumulator by shift-and-add, so a full
//   product takes ITER = WIDTH/BITS_PER_CYCLE cycles. Signed operands are
//   reduced to magnitudes plus a sign flag, and the sign is applied once at the
//   end.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   flush        : synchronous abort back to IDLE, overrides any handshake
//   in_valid     : operand request        in_ready : ready for operands (IDLE)
//   signed_mode  : 1 = two's complement, sampled with the operands
//   a, b         : multiplicand, multiplier (WIDTH bits)
//   out_valid    : product available (DONE)   out_ready : consumer accepts
//   product      : 2*WIDTH-bit result, held until the next completion
// -----------------------------------------------------------------------------
module seq_array_mult #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;     // multiplicand pre-shifted to the current row weight
  logic [WIDTH-1:0]     b_q, b_d;           // remaining multiplier bits, LSB-first
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   pp_s;               // partial product of this row slice

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      mag = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag = v;
    end
  endfunction

  // Two's-complement negation modulo 2^(2*WIDTH); negating zero gives zero.
  function automatic logic [2*WIDTH-1:0] neg2(input logic [2*WIDTH-1:0] v);
    neg2 = (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

  // Row-slice partial product plus next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_d       = b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    pp_s = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) begin
        pp_s = pp_s + (a_sh_q << j);
      end else begin
        pp_s = pp_s;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (signed_mode) begin
            a_sh_d = {{WIDTH{1'b0}}, mag(a)};
            b_d    = mag(b);
            neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          end else begin
            a_sh_d = {{WIDTH{1'b0}}, a};
            b_d    = b;
            neg_d  = 1'b0;
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_s;
        a_sh_d = a_sh_q << BITS_PER_CYCLE;
        b_d    = b_q >> BITS_PER_CYCLE;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_CNT) begin
          product_d = neg_q ? neg2(acc_d) : acc_d;
          state_d   = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An abort on the completing edge must not publish a result.
    if (flush) begin
      state_d   = IDLE;
      product_d = product_q;
    end else begin
      state_d   = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_array_mult
//   Drives three multiplier configurations (8/1, 8/4, 16/2) with directed and
//   random operands and compares products and handshake timing against an
//   integer-arithmetic reference.
// -----------------------------------------------------------------------------
module tb_seq_array_mult;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8, BPC=1
  logic        fl, iv, sm, ir, ov, ordy;
  logic [7:0]  a, b;
  logic [15:0] p;
  // WIDTH=8, BPC=4
  logic        iv4, sm4, ir4, ov4, or4;
  logic [7:0]  a4, b4;
  logic [15:0] p4;
  // WIDTH=16, BPC=2
  logic        iv16, sm16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        fl_off;

  int n_vec = 0;
  int n_err = 0;

  seq_array_mult #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_m8 (
    .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_ready(ir),
    .signed_mode(sm), .a(a), .b(b), .out_valid(ov), .out_ready(ordy), .product(p));

  seq_array_mult #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .flush(fl_off), .in_valid(iv4), .in_ready(ir4),
    .signed_mode(sm4), .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .product(p4));

  seq_array_mult #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_m16 (
    .clk(clk), .rst_n(rst_n), .flush(fl_off), .in_valid(iv16), .in_ready(ir16),
    .signed_mode(sm16), .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .product(p16));

  // Reference: interpret the operands as integers and multiply, then wrap.
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input int w);
    longint xs, ys, r;
    logic [63:0] mask;
    xs = longint'(x);
    ys = longint'(y);
    if (s && x[w-1]) xs = xs - (longint'(1) << w);
    if (s && y[w-1]) ys = ys - (longint'(1) << w);
    r    = xs * ys;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(r) & mask;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic s);
    a = x; b = y; sm = s; iv = 1'b1;
    tick();
    iv = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (ov !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Full transaction on the 8/1 unit: hold = cycles of back-pressure,
  // bp = offer new operands while the result is stalled.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                     input int hold, input logic bp);
    int cyc;
    logic [63:0] exp;
    exp = ref_mul({56'd0, x}, {56'd0, y}, s, 8);
    check_eq("rdy8", ir, 1'b1);
    start8(x, y, s);
    check_eq("busy8", {ov, ir}, 2'b00);
    wait8(cyc);
    check_eq("lat8", cyc, 8);
    check_eq("prod8", p, exp);
    for (int h = 0; h < hold; h++) begin
      if (bp) begin
        iv = 1'b1; a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom_range(0, 1));
      end
      tick();
      check_eq("hold_v8", {ov, ir}, 2'b10);
      check_eq("hold_p8", p, exp);
    end
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    check_eq("drain8", {ov, ir}, 2'b01);
  endtask

  task automatic op4(input logic [7:0] x, input logic [7:0] y, input logic s);
    int cyc;
    a4 = x; b4 = y; sm4 = s; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    cyc = 0;
    while (ov4 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check_eq("lat4", cyc, 2);
    check_eq("prod4", p4, ref_mul({56'd0, x}, {56'd0, y}, s, 8));
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    check_eq("drain4", {ov4, ir4}, 2'b01);
  endtask

  // out_ready16 is held high, so results drain on the edge after they appear.
  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s);
    int cyc;
    a16 = x; b16 = y; sm16 = s; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    cyc = 0;
    while (ov16 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check_eq("lat16", cyc, 8);
    check_eq("prod16", p16, ref_mul({48'd0, x}, {48'd0, y}, s, 16));
    tick();
    check_eq("drain16", {ov16, ir16}, 2'b01);
  endtask

  initial begin
    int cyc;
    logic seen;
    fl = 1'b0; iv = 1'b0; sm = 1'b0; ordy = 1'b0; a = 8'd0; b = 8'd0;
    iv4 = 1'b0; sm4 = 1'b0; or4 = 1'b0; a4 = 8'd0; b4 = 8'd0;
    iv16 = 1'b0; sm16 = 1'b0; or16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    fl_off = 1'b0;

    // Reset state
    #2;
    check_eq("rst_hs8", {ir, ov}, 2'b10);
    check_eq("rst_p8", p, 16'd0);
    check_eq("rst_hs4", {ir4, ov4}, 2'b10);
    check_eq("rst_hs16", {ir16, ov16}, 2'b10);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors
    op8(8'hFF, 8'hFF, 1'b0, 4, 1'b0);
    op8(8'h80, 8'h80, 1'b1, 0, 1'b0);
    op8(8'hFD, 8'h05, 1'b1, 1, 1'b0);
    op8(8'hFD, 8'h05, 1'b0, 0, 1'b0);
    op8(8'h3C, 8'hA5, 1'b1, 6, 1'b1);
    op8(8'h00, 8'hFD, 1'b1, 0, 1'b0);
    op8(8'h7F, 8'h00, 1'b0, 0, 1'b0);

    // Asynchronous reset three cycles into CALC
    start8(8'd100, 8'd3, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_hs", {ov, ir}, 2'b01);
    check_eq("arst_p", p, 16'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("arst_rdy", ir, 1'b1);
    op8(8'd7, 8'd9, 1'b0, 0, 1'b0);

    // Flush on the fifth CALC edge: nothing may come out
    start8(8'd50, 8'd60, 1'b0);
    repeat (4) tick();
    fl = 1'b1;
    tick();
    fl = 1'b0;
    check_eq("flc_hs", {ov, ir}, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | ov;
    end
    check_eq("flc_quiet", seen, 1'b0);

    // in_valid coincident with flush is not accepted
    a = 8'd5; b = 8'd5; sm = 1'b0; iv = 1'b1; fl = 1'b1;
    tick();
    iv = 1'b0; fl = 1'b0;
    check_eq("fl_noacc", ir, 1'b1);

    // Flush in DONE together with out_ready
    start8(8'd11, 8'd13, 1'b0);
    wait8(cyc);
    check_eq("fld_lat", cyc, 8);
    fl = 1'b1; ordy = 1'b1;
    tick();
    fl = 1'b0; ordy = 1'b0;
    check_eq("fld_hs", {ov, ir}, 2'b01);
    op8(8'd12, 8'd12, 1'b0, 0, 1'b0);

    // Random traffic on the 8/1 unit
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // 8/4 unit
    op4(8'd200, 8'd100, 1'b0);
    op4(8'h80, 8'h80, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op4(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // 16/2 unit, back-to-back with out_ready tied high
    or16 = 1'b1;
    op16(16'h8000, 16'h7FFF, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
    op16(16'h8000, 16'h8000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
